convert_pipe: RTL and testbench

Pipelined, multi-channel fixed-point requantiser: the parametrised successor to the combinational bit-width converter. Each of N_CHANNELS signed two's-complement lanes is re-aligned from (N_BITS_IN, BIN_PT_IN) to (N_BITS_OUT, BIN_PT_OUT). All alignment cases are covered: widening, narrowing, shift up, shift down, and disjoint ranges. The block adds sign extension, selectable rounding, selectable saturation/wrap, per-lane overflow flags and valid/ready flow control. It sits between DSP stages wherever word formats change.

---
 rtl/convert_pkg.sv | 29 ++
 rtl/convert_lane.sv | 80 ++++++++
 rtl/convert_pipe.sv | 75 +++++++
 tb/tb_convert_pipe.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/convert_pkg.sv
// Shared encodings and width helpers for the convert_pipe requantiser.
package convert_pkg;

  typedef enum logic [1:0] {
    QUANT_TRUNC     = 2'd0,
    QUANT_HALF_UP   = 2'd1,
    QUANT_HALF_EVEN = 2'd2
  } quant_e;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Rounding width: one carry bit above the input, widened if the bias itself needs more room.
  function automatic int rnd_width(input int nin, input int s);
    return (s > 0) ? imax(nin + 1, s + 1) : nin + 1;
  endfunction

  // Intermediate width: holds the aligned/rounded value and the full output range, plus a spare sign bit.
  function automatic int inter_width(input int nin, input int nout, input int s);
    return 1 + imax(nout, (s > 0) ? rnd_width(nin, s) : nin - s);
  endfunction

endpackage

// File: rtl/convert_lane.sv
// One lane of the requantiser: s1 aligns/rounds/sign-extends, s2 range-checks and saturates or wraps.
// Both stages advance only when en is high.
module convert_lane
  import convert_pkg::*;
#(
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int QUANTIZE   = 1,
  parameter int OVERFLOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [N_BITS_IN-1:0]  din,
  output logic [N_BITS_OUT-1:0] dout,
  output logic                  ovf
);

  localparam int S  = BIN_PT_IN - BIN_PT_OUT;
  localparam int RW = rnd_width(N_BITS_IN, S);
  localparam int WI = inter_width(N_BITS_IN, N_BITS_OUT, S);

  logic [WI-1:0] aligned;
  logic [WI-1:0] s1_q;

  generate
    if (S <= 0) begin : g_shl
      localparam int NSHL = -S;
      logic [WI-1:0] ext;
      assign ext     = {{(WI-N_BITS_IN){din[N_BITS_IN-1]}}, din};
      assign aligned = ext << NSHL;
    end else begin : g_shr
      logic        [RW-1:0] x_ext;
      logic        [RW-1:0] bias;
      logic        [RW-1:0] sum;
      logic signed [RW-1:0] shr;
      assign x_ext = {{(RW-N_BITS_IN){din[N_BITS_IN-1]}}, din};
      if (QUANTIZE == int'(QUANT_HALF_UP)) begin : g_hu
        localparam logic [RW-1:0] HALF = RW'(1) << (S - 1);
        assign bias = HALF;
      end else if (QUANTIZE == int'(QUANT_HALF_EVEN)) begin : g_he
        localparam logic [RW-1:0] HALF = RW'(1) << (S - 1);
        // x_ext[S] is the LSB that survives the shift; it breaks ties toward even.
        assign bias = HALF - RW'(1) + {{(RW-1){1'b0}}, x_ext[S]};
      end else begin : g_tr
        assign bias = '0;
      end
      assign sum     = x_ext + bias;
      assign shr     = $signed(sum) >>> S;
      assign aligned = {{(WI-RW){shr[RW-1]}}, shr};
    end
  endgenerate

  logic [WI-N_BITS_OUT:0] hi;
  logic                   over;
  logic [N_BITS_OUT-1:0]  sat_val;
  logic [N_BITS_OUT-1:0]  res;

  // In range only if every bit from the output sign upward matches.
  assign hi      = s1_q[WI-1:N_BITS_OUT-1];
  assign over    = !((&hi) || !(|hi));
  assign sat_val = s1_q[WI-1] ? {1'b1, {(N_BITS_OUT-1){1'b0}}}
                              : {1'b0, {(N_BITS_OUT-1){1'b1}}};
  assign res     = (over && (OVERFLOW == int'(OVF_SAT))) ? sat_val : s1_q[N_BITS_OUT-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      dout <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      s1_q <= aligned;
      dout <= res;
      ovf  <= over;
    end
  end

endmodule

// File: rtl/convert_pipe.sv
// Two-stage multi-lane fixed-point requantiser with valid/ready handshake; latency 2, 1 word/cycle.
// Define CONVERT_PIPE_OVF_CNT_EN to add a saturating ovf_count output.
module convert_pipe
  import convert_pkg::*;
#(
  parameter int N_CHANNELS = 1,
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int QUANTIZE   = 1,
  parameter int OVERFLOW   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CHANNELS*N_BITS_IN-1:0]  din,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [N_CHANNELS*N_BITS_OUT-1:0] dout,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N_CHANNELS-1:0]            ovf
`ifdef CONVERT_PIPE_OVF_CNT_EN
  ,
  output logic [31:0]                      ovf_count
`endif
);

  logic en;
  logic s1_valid;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  generate
    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_lane
      convert_lane #(
        .N_BITS_IN (N_BITS_IN),
        .BIN_PT_IN (BIN_PT_IN),
        .N_BITS_OUT(N_BITS_OUT),
        .BIN_PT_OUT(BIN_PT_OUT),
        .QUANTIZE  (QUANTIZE),
        .OVERFLOW  (OVERFLOW)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .din (din[i*N_BITS_IN +: N_BITS_IN]),
        .dout(dout[i*N_BITS_OUT +: N_BITS_OUT]),
        .ovf (ovf[i])
      );
    end
  endgenerate

`ifdef CONVERT_PIPE_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (out_valid && out_ready && (|ovf) && !(&ovf_count)) begin
      ovf_count <= ovf_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_convert_pipe.sv
// Directed bench for convert_pipe: format vectors across several configurations, then handshake corner cases.
module tb_convert_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, req);
    end
  endtask

  // Shared stimulus for the single-lane instances.
  logic [7:0] din8 = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;

  logic       rdy_q1s, rdy_q1w, rdy_q0, rdy_q2, rdy_w;
  logic       vld_q1s, vld_q1w, vld_q0, vld_q2, vld_w;
  logic [3:0] d_q1s, d_q1w, d_q0, d_q2;
  logic [11:0] d_w;
  logic       o_q1s, o_q1w, o_q0, o_q2, o_w;

  convert_pipe u_q1s (.clk(clk), .rst(rst), .din(din8), .in_valid(in_valid), .in_ready(rdy_q1s),
                      .dout(d_q1s), .out_valid(vld_q1s), .out_ready(out_ready), .ovf(o_q1s));
  convert_pipe #(.OVERFLOW(0)) u_q1w (.clk(clk), .rst(rst), .din(din8), .in_valid(in_valid), .in_ready(rdy_q1w),
                      .dout(d_q1w), .out_valid(vld_q1w), .out_ready(out_ready), .ovf(o_q1w));
  convert_pipe #(.QUANTIZE(0)) u_q0 (.clk(clk), .rst(rst), .din(din8), .in_valid(in_valid), .in_ready(rdy_q0),
                      .dout(d_q0), .out_valid(vld_q0), .out_ready(out_ready), .ovf(o_q0));
  convert_pipe #(.QUANTIZE(2)) u_q2 (.clk(clk), .rst(rst), .din(din8), .in_valid(in_valid), .in_ready(rdy_q2),
                      .dout(d_q2), .out_valid(vld_q2), .out_ready(out_ready), .ovf(o_q2));
  convert_pipe #(.N_BITS_OUT(12), .BIN_PT_OUT(9)) u_wide (.clk(clk), .rst(rst), .din(din8), .in_valid(in_valid),
                      .in_ready(rdy_w), .dout(d_w), .out_valid(vld_w), .out_ready(out_ready), .ovf(o_w));

  // Two-lane instance for handshake tests.
  logic [15:0] bp_din = '0;
  logic        bp_in_valid = 1'b0;
  logic        bp_in_ready;
  logic [7:0]  bp_dout;
  logic        bp_out_valid;
  logic        bp_out_ready = 1'b1;
  logic [1:0]  bp_ovf;

  convert_pipe #(.N_CHANNELS(2)) u_bp (.clk(clk), .rst(rst), .din(bp_din), .in_valid(bp_in_valid),
                      .in_ready(bp_in_ready), .dout(bp_dout), .out_valid(bp_out_valid),
                      .out_ready(bp_out_ready), .ovf(bp_ovf));

  // Reference for the default format (8/7 -> 4/3, half up, saturate): returns {ovf, dout}.
  function automatic logic [4:0] mdl(input logic [7:0] x);
    int v;
    v = int'($signed(x));
    v = (v + 8) >>> 4;
    if (v > 7)  return {1'b1, 4'h7};
    if (v < -8) return {1'b1, 4'h8};
    return {1'b0, v[3:0]};
  endfunction

  // Expected {ovf1, ovf0, dout1, dout0} for a two-lane word.
  function automatic logic [9:0] mdl2(input logic [15:0] w);
    logic [4:0] a, b;
    a = mdl(w[7:0]);
    b = mdl(w[15:8]);
    return {b[4], a[4], b[3:0], a[3:0]};
  endfunction

  function automatic logic [15:0] word(input int i);
    logic [7:0] l0, l1;
    l0 = 8'(i * 37 + 3);
    l1 = 8'(8'h90 + i * 29);
    return {l1, l0};
  endfunction

  typedef struct {
    logic [7:0]  din;
    logic [3:0]  q1s; logic o1s;
    logic [3:0]  q1w; logic o1w;
    logic [3:0]  q0;  logic o0;
    logic [3:0]  q2;  logic o2;
    logic [11:0] w;
  } vec_t;

  vec_t vt [11];
  logic [15:0] q [$];

  initial begin
    vt[0]  = '{8'h7F, 4'h7, 1'b1, 4'h8, 1'b1, 4'h7, 1'b0, 4'h7, 1'b1, 12'h1FC};
    vt[1]  = '{8'h08, 4'h1, 1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 12'h020};
    vt[2]  = '{8'hF8, 4'h0, 1'b0, 4'h0, 1'b0, 4'hF, 1'b0, 4'h0, 1'b0, 12'hFE0};
    vt[3]  = '{8'h80, 4'h8, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0, 12'hE00};
    vt[4]  = '{8'hC0, 4'hC, 1'b0, 4'hC, 1'b0, 4'hC, 1'b0, 4'hC, 1'b0, 12'hF00};
    vt[5]  = '{8'h18, 4'h2, 1'b0, 4'h2, 1'b0, 4'h1, 1'b0, 4'h2, 1'b0, 12'h060};
    vt[6]  = '{8'h28, 4'h3, 1'b0, 4'h3, 1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 12'h0A0};
    vt[7]  = '{8'h78, 4'h7, 1'b1, 4'h8, 1'b1, 4'h7, 1'b0, 4'h7, 1'b1, 12'h1E0};
    vt[8]  = '{8'h00, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 12'h000};
    vt[9]  = '{8'h81, 4'h8, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0, 4'h8, 1'b0, 12'hE04};
    vt[10] = '{8'h77, 4'h7, 1'b0, 4'h7, 1'b0, 4'h7, 1'b0, 4'h7, 1'b0, 12'h1DC};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'({vld_q1s, vld_q1w, vld_q0, vld_q2, vld_w, bp_out_valid}), 32'h0);
    check("rst_dout", 32'({d_q1s, d_q0, d_w, bp_dout}), 32'h0);
    check("rst_ovf", 32'({o_q1s, o_q1w, o_q0, o_q2, o_w, bp_ovf}), 32'h0);
    check("rst_in_ready", 32'({rdy_q1s, rdy_q1w, rdy_q0, rdy_q2, rdy_w, bp_in_ready}), 32'h3F);

    // Format vectors: one word at a time, checking 2-cycle latency.
    for (int i = 0; i < 11; i++) begin
      din8 = vt[i].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_not_1", 32'(vld_q1s), 32'h0);
      @(negedge clk);
      check("lat_2_valid", 32'({vld_q1s, vld_q1w, vld_q0, vld_q2, vld_w}), 32'h1F);
      check("q1_sat", 32'({o_q1s, d_q1s}), 32'({vt[i].o1s, vt[i].q1s}));
      check("q1_wrap", 32'({o_q1w, d_q1w}), 32'({vt[i].o1w, vt[i].q1w}));
      check("q0_trunc", 32'({o_q0, d_q0}), 32'({vt[i].o0, vt[i].q0}));
      check("q2_even", 32'({o_q2, d_q2}), 32'({vt[i].o2, vt[i].q2}));
      check("widen", 32'({o_w, d_w}), 32'({1'b0, vt[i].w}));
      @(negedge clk);
      check("drained", 32'(vld_q1s), 32'h0);
    end

    // Unstalled latency on the two-lane instance.
    bp_out_ready = 1'b1;
    bp_din = 16'h7F08;
    bp_in_valid = 1'b1;
    @(negedge clk);
    bp_in_valid = 1'b0;
    check("bp_lat_not_1", 32'(bp_out_valid), 32'h0);
    @(negedge clk);
    check("bp_lat_2", 32'(bp_out_valid), 32'h1);
    check("bp_lat_dat", 32'({bp_ovf, bp_dout}), 32'({2'b10, 4'h7, 4'h1}));
    @(negedge clk);

    // Backpressure stream with pseudo-random out_ready.
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      logic prev_stall = 1'b0;
      logic [9:0] prev_dat = '0;
      while (got < 10 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        if (prev_stall) begin
          check("hold_valid", 32'(bp_out_valid), 32'h1);
          check("hold_data", 32'({bp_ovf, bp_dout}), 32'(prev_dat));
        end
        bp_out_ready = ($urandom_range(0, 2) != 0);
        if (sent < 10) begin
          bp_din = word(sent);
          bp_in_valid = 1'b1;
        end else begin
          bp_in_valid = 1'b0;
        end
        #1;
        if (bp_out_valid && bp_out_ready) begin
          check("bp_have_expect", 32'(q.size() != 0), 32'h1);
          if (q.size() != 0) check("bp_word", 32'({bp_ovf, bp_dout}), 32'(mdl2(q.pop_front())));
          got++;
        end
        if (bp_in_valid && bp_in_ready) begin
          q.push_back(bp_din);
          sent++;
        end
        prev_stall = bp_out_valid && !bp_out_ready;
        prev_dat = {bp_ovf, bp_dout};
      end
      check("bp_count", 32'(got), 32'd10);
      check("bp_sent", 32'(sent), 32'd10);
      @(negedge clk);
      bp_in_valid = 1'b0;
      bp_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("bp_no_dup", 32'(bp_out_valid), 32'h0);
      end
    end

    // Reset with two words in flight: both are dropped.
    bp_out_ready = 1'b1;
    bp_din = word(1);
    bp_in_valid = 1'b1;
    @(negedge clk);
    bp_din = word(2);
    @(negedge clk);
    bp_in_valid = 1'b0;
    check("pre_rst_valid", 32'(bp_out_valid), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 32'(bp_out_valid), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(bp_out_valid), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
